ex_operand_stage: RTL and testbench

- ID/EX pipeline register plus EX-stage operand forwarding for the 5-stage MIPS core. Sits directly upstream of the execute ALU.
- Captures decoded instruction fields at the clock edge. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives the ALU's ctrl, in_0 and in_1 inputs.
- Detects load-use hazards, inserts bubbles, and honours global stall and branch-mispredict flush.

---
 rtl/ex_operand_stage.sv | 178 +++++++++++++++++
 tb/tb_ex_operand_stage.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage
//   ID/EX pipeline register and EX-stage operand forwarding for the 5-stage
//   MIPS core. It captures the decoded instruction and resolves RAW hazards by
//   forwarding from EX/MEM and MEM/WB, with EX/MEM taking priority. It raises
//   load_use_hazard and inserts a bubble for a load-use dependency, and it
//   counts inserted bubbles in a saturating counter.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             global freeze; all state holds
//   flush             branch mispredict; squash the instruction entering EX
//   id_*              decoded fields of the instruction currently in ID
//   exmem_*, memwb_*  destination/result of downstream stages for forwarding
//   load_use_hazard   combinational; ID/IF must hold this cycle
//   alu_ctrl, alu_in_0, alu_in_1   ALU opcode and operands
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd   registered control
//   ex_store_data     forwarded rt value for stores
//   bubble_cnt        saturating count of inserted bubbles
module ex_operand_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_ctrl,
    input  logic [REG_W-1:0]  id_rs_idx,
    input  logic [REG_W-1:0]  id_rt_idx,
    input  logic [REG_W-1:0]  id_rd_idx,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [4:0]        id_shamt,
    input  logic              id_use_imm,
    input  logic              id_use_shamt,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic [REG_W-1:0]  memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_hazard,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_in_0,
    output logic [DATA_W-1:0] alu_in_1,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam logic [3:0] ALU_SLL = 4'b1010;
    localparam logic [3:0] ALU_SRA = 4'b1011;
    localparam logic [3:0] ALU_SRL = 4'b1100;

    logic [REG_W-1:0]  rs_idx_q;
    logic [REG_W-1:0]  rt_idx_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [4:0]        shamt_q;
    logic              use_imm_q;
    logic              use_shamt_q;

    logic              squash;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              is_shift;

    // Load in EX whose destination is read by the instruction in ID.
    always_comb begin
        load_use_hazard = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                          ((id_use_rs && (id_rs_idx == ex_rd)) ||
                           (id_use_rt && (id_rt_idx == ex_rd)));
    end

    assign squash = flush || load_use_hazard;

    // A squashed slot and an empty ID slot both write a bubble; only a
    // squash is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            alu_ctrl     <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_rd        <= '0;
            rs_idx_q     <= '0;
            rt_idx_q     <= '0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            shamt_q      <= '0;
            use_imm_q    <= 1'b0;
            use_shamt_q  <= 1'b0;
            bubble_cnt   <= '0;
        end else if (!stall) begin
            if (squash || !id_valid) begin
                ex_valid     <= 1'b0;
                alu_ctrl     <= '0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_rd        <= '0;
                rs_idx_q     <= '0;
                rt_idx_q     <= '0;
                rs_data_q    <= '0;
                rt_data_q    <= '0;
                imm_q        <= '0;
                shamt_q      <= '0;
                use_imm_q    <= 1'b0;
                use_shamt_q  <= 1'b0;
                if (squash && (bubble_cnt != '1)) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
            end else begin
                ex_valid     <= 1'b1;
                alu_ctrl     <= id_alu_ctrl;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
                ex_mem_write <= id_mem_write;
                ex_rd        <= id_rd_idx;
                rs_idx_q     <= id_rs_idx;
                rt_idx_q     <= id_rt_idx;
                rs_data_q    <= id_rs_data;
                rt_data_q    <= id_rt_data;
                imm_q        <= id_imm;
                shamt_q      <= id_shamt;
                use_imm_q    <= id_use_imm;
                use_shamt_q  <= id_use_shamt;
            end
        end
    end

    // MEM/WB is applied first so that a later EX/MEM match overrides it.
    always_comb begin
        fwd_rs = rs_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_idx_q)) begin
            fwd_rs = memwb_result;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_idx_q)) begin
            fwd_rs = exmem_result;
        end
        fwd_rt = rt_data_q;
        if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_idx_q)) begin
            fwd_rt = memwb_result;
        end
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_idx_q)) begin
            fwd_rt = exmem_result;
        end
    end

    always_comb begin
        is_shift = use_shamt_q &&
                   ((alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRA) || (alu_ctrl == ALU_SRL));
        if (is_shift) begin
            alu_in_0 = DATA_W'(shamt_q);
            alu_in_1 = fwd_rt;
        end else begin
            alu_in_0 = fwd_rs;
            alu_in_1 = use_imm_q ? imm_q : fwd_rt;
        end
        ex_store_data = fwd_rt;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic        clk;
    logic        rst, stall, flush;
    logic        id_valid;
    logic [3:0]  id_alu_ctrl;
    logic [4:0]  id_rs_idx, id_rt_idx, id_rd_idx;
    logic        id_use_rs, id_use_rt;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_shamt;
    logic        id_use_imm, id_use_shamt;
    logic        id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  exmem_rd;
    logic        exmem_reg_write;
    logic [31:0] exmem_result;
    logic [4:0]  memwb_rd;
    logic        memwb_reg_write;
    logic [31:0] memwb_result;
    logic        load_use_hazard;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_in_0, alu_in_1;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic [31:0] ex_store_data;
    logic [TB_CNT_W-1:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    ex_operand_stage #(.DATA_W(32), .REG_W(5), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_alu_ctrl(id_alu_ctrl),
        .id_rs_idx(id_rs_idx), .id_rt_idx(id_rt_idx), .id_rd_idx(id_rd_idx),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_shamt(id_shamt), .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
        .load_use_hazard(load_use_hazard), .alu_ctrl(alu_ctrl),
        .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_rd(ex_rd), .ex_store_data(ex_store_data), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the instruction sitting in EX, plus the bubble count.
    typedef struct {
        logic        v;
        logic [3:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  sh;
        logic        ui, us, rw, mr, mw;
    } ex_t;

    ex_t m;
    int  mcnt;

    function automatic ex_t empty_slot();
        ex_t e;
        e.v = 0; e.ctrl = 0; e.rs = 0; e.rt = 0; e.rd = 0;
        e.rsd = 0; e.rtd = 0; e.imm = 0; e.sh = 0;
        e.ui = 0; e.us = 0; e.rw = 0; e.mr = 0; e.mw = 0;
        return e;
    endfunction

    function automatic logic [31:0] m_fwd(logic [4:0] idx, logic [31:0] own);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
        return own;
    endfunction

    function automatic logic m_hazard();
        if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (id_use_rs && id_rs_idx == m.rd) || (id_use_rt && id_rt_idx == m.rd);
    endfunction

    function automatic logic m_is_shift();
        return m.us && (m.ctrl == 4'd10 || m.ctrl == 4'd11 || m.ctrl == 4'd12);
    endfunction

    function automatic logic [31:0] m_in0();
        if (m_is_shift()) return {27'd0, m.sh};
        return m_fwd(m.rs, m.rsd);
    endfunction

    function automatic logic [31:0] m_in1();
        if (m_is_shift()) return m_fwd(m.rt, m.rtd);
        return m.ui ? m.imm : m_fwd(m.rt, m.rtd);
    endfunction

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        logic hz;
        hz = m_hazard();
        @(posedge clk);
        if (rst) begin
            m = empty_slot();
            mcnt = 0;
        end else if (!stall) begin
            if (flush || hz) begin
                m = empty_slot();
                if (mcnt < CNT_MAX) mcnt++;
            end else if (!id_valid) begin
                m = empty_slot();
            end else begin
                m.v = 1; m.ctrl = id_alu_ctrl;
                m.rs = id_rs_idx; m.rt = id_rt_idx; m.rd = id_rd_idx;
                m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm; m.sh = id_shamt;
                m.ui = id_use_imm; m.us = id_use_shamt;
                m.rw = id_reg_write; m.mr = id_mem_read; m.mw = id_mem_write;
            end
        end
        #1;
    endtask

    task automatic set_idle();
        rst = 0; stall = 0; flush = 0;
        id_valid = 0; id_alu_ctrl = 0; id_rs_idx = 0; id_rt_idx = 0; id_rd_idx = 0;
        id_use_rs = 0; id_use_rt = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_shamt = 0; id_use_imm = 0; id_use_shamt = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic rand_inputs();
        id_valid = ($urandom_range(0, 7) != 0);
        id_alu_ctrl = 4'($urandom_range(0, 15));
        id_rs_idx = 5'($urandom_range(0, 7));
        id_rt_idx = 5'($urandom_range(0, 7));
        id_rd_idx = 5'($urandom_range(0, 7));
        id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_shamt = 5'($urandom);
        id_use_imm = 1'($urandom); id_use_shamt = 1'($urandom);
        id_reg_write = 1'($urandom);
        id_mem_read = ($urandom_range(0, 2) == 0);
        id_mem_write = 1'($urandom);
        exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom);
        exmem_result = $urandom;
        memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom);
        memwb_result = $urandom;
    endtask

    task automatic test_reset();
        set_idle();
        rand_inputs();
        rst = 1;
        tick();
        tick();
        #2;
        n_cmp++;
        if ({alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ctrl=%h v=%b rw=%b mr=%b mw=%b rd=%0d want all 0",
                     alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd);
        end
        n_cmp++;
        if (alu_in_0 !== 32'd0 || alu_in_1 !== 32'd0 || ex_store_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data: got in0=%h in1=%h st=%h want 0", alu_in_0, alu_in_1, ex_store_data);
        end
        n_cmp++;
        if (bubble_cnt !== 0 || load_use_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_cnt_hz: got cnt=%0d hz=%b want 0/0", bubble_cnt, load_use_hazard);
        end
        set_idle();
    endtask

    task automatic test_forwarding();
        set_idle();
        id_valid = 1; id_alu_ctrl = 4'b0010; id_rs_idx = 3; id_rt_idx = 4; id_rd_idx = 5;
        id_use_rs = 1; id_use_rt = 1; id_rs_data = 1; id_rt_data = 2; id_reg_write = 1;
        tick();
        stall = 1; id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h10;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h20;
        #2;
        n_cmp++;
        if (alu_in_0 !== 32'h10 || alu_in_1 !== 32'h2 || alu_ctrl !== 4'b0010 || ex_rd !== 5'd5) begin
            n_bad++;
            $display("FAIL fwd_exmem_prio: got in0=%h in1=%h ctrl=%h rd=%0d want 10/2/2/5",
                     alu_in_0, alu_in_1, alu_ctrl, ex_rd);
        end
        tick();
        exmem_reg_write = 0; memwb_rd = 4; memwb_result = 32'h30;
        #2;
        n_cmp++;
        if (alu_in_0 !== 32'h1 || alu_in_1 !== 32'h30 || ex_store_data !== 32'h30) begin
            n_bad++;
            $display("FAIL fwd_memwb_rt: got in0=%h in1=%h st=%h want 1/30/30",
                     alu_in_0, alu_in_1, ex_store_data);
        end
        tick();
        set_idle();
        id_valid = 1; id_rs_idx = 0; id_rt_idx = 0; id_rs_data = 7; id_rt_data = 9;
        tick();
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hdead;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hbeef;
        #2;
        n_cmp++;
        if (alu_in_0 !== 32'd7 || alu_in_1 !== 32'd9) begin
            n_bad++;
            $display("FAIL fwd_rd_zero: got in0=%h in1=%h want 7/9", alu_in_0, alu_in_1);
        end
        set_idle();
    endtask

    task automatic test_shift();
        set_idle();
        id_valid = 1; id_alu_ctrl = 4'b1010; id_shamt = 5; id_rt_data = 1; id_rs_data = 32'h77;
        id_rs_idx = 7; id_rt_idx = 6; id_use_shamt = 1;
        tick();
        #2;
        n_cmp++;
        if (alu_in_0 !== 32'd5 || alu_in_1 !== 32'd1) begin
            n_bad++;
            $display("FAIL shift_sll: got in0=%h in1=%h want 5/1", alu_in_0, alu_in_1);
        end
        id_alu_ctrl = 4'b0010;  // use_shamt on a non-shift op selects rs
        tick();
        #2;
        n_cmp++;
        if (alu_in_0 !== 32'h77 || alu_in_1 !== 32'd1) begin
            n_bad++;
            $display("FAIL shift_nonshift_op: got in0=%h in1=%h want 77/1", alu_in_0, alu_in_1);
        end
        set_idle();
    endtask

    task automatic test_load_use();
        int c0;
        set_idle();
        id_valid = 1; id_alu_ctrl = 4'b0010; id_rd_idx = 8; id_mem_read = 1; id_reg_write = 1;
        id_rs_idx = 2; id_use_rs = 1;
        tick();
        id_mem_read = 0; id_rd_idx = 10; id_rs_idx = 8; id_use_rs = 1; id_rt_idx = 9; id_use_rt = 1;
        #2;
        n_cmp++;
        if (load_use_hazard !== 1'b1) begin
            n_bad++;
            $display("FAIL loaduse_detect: got hz=%b want 1", load_use_hazard);
        end
        c0 = mcnt;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || bubble_cnt !== TB_CNT_W'(c0 + 1)) begin
            n_bad++;
            $display("FAIL loaduse_bubble: got v=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0 + 1);
        end
        id_rd_idx = 8; id_mem_read = 1; id_rs_idx = 2;
        tick();
        id_mem_read = 0; id_rd_idx = 10; id_rs_idx = 8; id_use_rs = 0; id_rt_idx = 9;
        #2;
        n_cmp++;
        if (load_use_hazard !== 1'b0) begin
            n_bad++;
            $display("FAIL loaduse_no_use_rs: got hz=%b want 0", load_use_hazard);
        end
        tick();
        n_cmp++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd10) begin
            n_bad++;
            $display("FAIL loaduse_no_bubble: got v=%b rd=%0d want 1/10", ex_valid, ex_rd);
        end
        set_idle();
    endtask

    task automatic test_stall_flush();
        int c0;
        set_idle();
        id_valid = 1; id_alu_ctrl = 4'b0110; id_rd_idx = 12; id_reg_write = 1;
        tick();
        c0 = mcnt;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1; flush = 1;
            tick();
            n_cmp++;
            if (ex_valid !== 1'b1 || ex_rd !== 5'd12 || alu_ctrl !== 4'b0110 || bubble_cnt !== TB_CNT_W'(c0)) begin
                n_bad++;
                $display("FAIL stall_hold_%0d: got v=%b rd=%0d ctrl=%h cnt=%0d want 1/12/6/%0d",
                         i, ex_valid, ex_rd, alu_ctrl, bubble_cnt, c0);
            end
        end
        stall = 0;
        tick();
        n_cmp++;
        if (ex_valid !== 1'b0 || bubble_cnt !== TB_CNT_W'(c0 + 1)) begin
            n_bad++;
            $display("FAIL flush_after_stall: got v=%b cnt=%0d want 0/%0d", ex_valid, bubble_cnt, c0 + 1);
        end
        set_idle();
    endtask

    task automatic test_saturation();
        set_idle();
        flush = 1;
        repeat (CNT_MAX + 2) tick();
        n_cmp++;
        if (bubble_cnt !== TB_CNT_W'(CNT_MAX)) begin
            n_bad++;
            $display("FAIL sat_reach: got cnt=%0d want %0d", bubble_cnt, CNT_MAX);
        end
        tick();
        n_cmp++;
        if (bubble_cnt !== TB_CNT_W'(CNT_MAX) || ex_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_hold: got cnt=%0d v=%b want %0d/0", bubble_cnt, ex_valid, CNT_MAX);
        end
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            rst   = ($urandom_range(0, 63) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            #2;
            n_cmp++;
            if (load_use_hazard !== m_hazard()) begin
                n_bad++;
                $display("FAIL rand_hz[%0d]: got %b want %b", i, load_use_hazard, m_hazard());
            end
            n_cmp++;
            if (alu_in_0 !== m_in0() || alu_in_1 !== m_in1() || ex_store_data !== m_fwd(m.rt, m.rtd)) begin
                n_bad++;
                $display("FAIL rand_data[%0d]: got %h/%h/%h want %h/%h/%h", i, alu_in_0, alu_in_1,
                         ex_store_data, m_in0(), m_in1(), m_fwd(m.rt, m.rtd));
            end
            n_cmp++;
            if ({alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd} !==
                {m.ctrl, m.v, m.rw, m.mr, m.mw, m.rd} || bubble_cnt !== TB_CNT_W'(mcnt)) begin
                n_bad++;
                $display("FAIL rand_ctrl[%0d]: got ctrl=%h v%b rw%b mr%b mw%b rd=%0d cnt=%0d want ctrl=%h v%b rw%b mr%b mw%b rd=%0d cnt=%0d",
                         i, alu_ctrl, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, bubble_cnt,
                         m.ctrl, m.v, m.rw, m.mr, m.mw, m.rd, mcnt);
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        m = empty_slot();
        mcnt = 0;
        set_idle();
        test_reset();
        test_forwarding();
        test_shift();
        test_load_use();
        test_stall_flush();
        test_saturation();
        rst = 1;
        tick();
        set_idle();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
